fpu_addsub_issue: RTL and testbench
===================================

# fpu_addsub_issue

Issue/writeback controller directly upstream of the add/sub FPU FSM. It accepts FADD.S/FSUB.S requests from the RV32IMF execute stage and resolves NaN/Inf operands locally in one cycle. All other operands go to the FSM over its start/done handshake, and the result returns to the register-file writeback port with backpressure. It is the only agent allowed to drive the FSM's start, sel, N1 and N2 inputs.

## Interface
Parameters:
- CANON_NAN, 32'h7FC0_0000, quiet NaN returned for every invalid/NaN case
- RD_W, 5, destination register index width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  1  0 = add, 1 = subtract (rs1 − rs2)
- req_rs1, req_rs2  in  32  IEEE-754 single operands
- req_rd  in  RD_W  destination register
- flush  in  1  kill any in-flight request (branch mispredict/trap)
- fsm_start  out  1  to FSM start
- fsm_sel  out  1  to FSM sel (0 add, 1 sub)
- fsm_n1, fsm_n2  out  32  to FSM N1/N2
- fsm_done  in  1  from FSM done
- fsm_result  in  32  from FSM result
- wb_valid  out  1  writeback data valid
- wb_ready  in  1  writeback consumed when wb_valid && wb_ready
- wb_rd  out  RD_W  destination register
- wb_data  out  32  result
- busy  out  1  state != IDLE; execute-stage stall

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, WB.
- IDLE: req_ready = !flush. On accept, latch op, rs1, rs2 and rd into holding registers. fsm_n1, fsm_n2 and fsm_sel are driven from these registers and stay stable until DRAIN exits.
- Special detection at accept (exp == 8'hFF):
  - eff_sub = op ^ rs1[31] ^ rs2[31].
  - Either operand NaN (mantissa != 0) -> CANON_NAN.
  - Both Inf and eff_sub -> CANON_NAN.
  - Only rs1 Inf, or both Inf with !eff_sub -> {rs1[31], 8'hFF, 23'd0}.
  - Only rs2 Inf -> {rs2[31]^op, 8'hFF, 23'd0}.
  - A special result loads wb_data directly and goes IDLE -> WB. The FSM is not started.
- Zeros, denormals and finite values go IDLE -> ISSUE.
- ISSUE (1 cycle): fsm_start = 1. Next state is WAIT.
- WAIT: fsm_start held at 1. When fsm_done = 1, capture fsm_result into wb_data and go to DRAIN.
- DRAIN: fsm_start = 0. Stay until fsm_done = 0. Then go to WB, or to IDLE if killed.
- WB: wb_valid = 1 until wb_ready, then go to IDLE.
- Flush:
  - In ISSUE, WAIT or DRAIN: set the kill flag. The FSM cannot be aborted, so the handshake runs to completion, but nothing is written back.
  - In WB: drop wb_valid and go to IDLE next cycle.
  - In IDLE: no accept that cycle.
- The FSM is never restarted while fsm_done = 1. A new request is accepted only from IDLE.

## Timing
- Reset (rst_n low, async): state IDLE; fsm_start, fsm_sel, wb_valid, busy, kill = 0; fsm_n1, fsm_n2, wb_data = 0; wb_rd = 0; req_ready = 1 once rst_n is high.
- The FSM's reset is driven from ~rst_n. rst_n must be held low for at least 2 clk edges so the FSM, which has a synchronous reset, also returns to IDLE.
- Bypass latency: accept at cycle 0, wb_valid in cycle 1.
- FSM path with the current FSM:
  - Accept at cycle 0; fsm_start high in cycles 1–8.
  - fsm_done seen in cycle 8; DRAIN in cycles 9–11; fsm_done low in cycle 11.
  - wb_valid in cycle 12.
- Control must be purely handshake-driven, with no fixed count anywhere.
- wb_rd and wb_data must be stable while wb_valid = 1 && wb_ready = 0.
- Throughput: at most one request in flight. busy = 1 from the cycle after accept until the cycle after the WB handshake.

## Test plan
- Add, FSM path: rs1 = 0x3FC00000, rs2 = 0x40100000, op = 0, rd = 7 -> wb_data = 0x40700000 and wb_rd = 7 in cycle 12. fsm_start high for exactly cycles 1–8.
- Subtract, FSM path: rs1 = 0x40400000, rs2 = 0x3F800000, op = 1 -> wb_data = 0x40000000. fsm_sel = 1 and fsm_n1/fsm_n2 stable through DRAIN.
- Specials, bypass path:
  - 0x7F800000 − 0x7F800000 -> 0x7FC00000 at cycle 1, fsm_start never asserted.
  - 0x7F800000 + 0x3F800000 -> 0x7F800000.
  - 0x3F800000 − 0xFF800000 -> 0x7F800000.
  - 0x7FA00000 + anything -> 0x7FC00000.
- Backpressure: wb_ready low for 5 cycles after wb_valid -> data and rd held constant, req_ready = 0, single writeback on release.
- Flush:
  - Pulse in cycle 4 -> no wb_valid; handshake completes (fsm_done falls); req_ready = 1 by cycle 12; the next add returns the correct result.
  - Flush in WB -> wb_valid drops next cycle.
- Reset mid-operation: rst_n low for 2 cycles in WAIT -> all outputs 0 immediately, FSM back in IDLE. A fresh request then completes normally.

Source files
------------

// File: rtl/fpu_addsub_issue.sv
// Issue/writeback controller for the add/sub FPU FSM. It resolves NaN/Inf operands in one
// cycle, runs the FSM start/done handshake for every other operand, and holds the result for writeback.
module fpu_addsub_issue #(
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000,
    parameter int          RD_W      = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_op,
    input  logic [31:0]     req_rs1,
    input  logic [31:0]     req_rs2,
    input  logic [RD_W-1:0] req_rd,
    input  logic            flush,
    output logic            fsm_start,
    output logic            fsm_sel,
    output logic [31:0]     fsm_n1,
    output logic [31:0]     fsm_n2,
    input  logic            fsm_done,
    input  logic [31:0]     fsm_result,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            busy
);

    // state | meaning
    // IDLE  | waiting for a request; the only state that accepts one
    // ISSUE | first cycle of fsm_start
    // WAIT  | fsm_start held until the FSM raises done
    // DRAIN | waiting for done to fall before the FSM can be reused
    // WB    | result presented on the writeback port
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_WB
    } state_t;

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic [31:0]       n1_q, n1_d;
    logic [31:0]       n2_q, n2_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              kill_q, kill_d;

    logic        exp1_max, exp2_max;
    logic        nan1, nan2, inf1, inf2;
    logic        eff_sub;
    logic        special;
    logic [31:0] special_res;

    always_comb begin
        exp1_max = (req_rs1[30:23] == 8'hFF);
        exp2_max = (req_rs2[30:23] == 8'hFF);
        nan1     = exp1_max && (req_rs1[22:0] != 23'd0);
        nan2     = exp2_max && (req_rs2[22:0] != 23'd0);
        inf1     = exp1_max && (req_rs1[22:0] == 23'd0);
        inf2     = exp2_max && (req_rs2[22:0] == 23'd0);
        eff_sub  = req_op ^ req_rs1[31] ^ req_rs2[31];
        special  = exp1_max || exp2_max;

        if (nan1 || nan2) begin
            special_res = CANON_NAN;
        end else if (inf1 && inf2) begin
            special_res = eff_sub ? CANON_NAN : {req_rs1[31], 8'hFF, 23'd0};
        end else if (inf1) begin
            special_res = {req_rs1[31], 8'hFF, 23'd0};
        end else begin
            special_res = {req_rs2[31] ^ req_op, 8'hFF, 23'd0};
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        n1_d      = n1_q;
        n2_d      = n2_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        kill_d    = kill_q;
        req_ready = 1'b0;
        fsm_start = 1'b0;
        wb_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    op_d   = req_op;
                    n1_d   = req_rs1;
                    n2_d   = req_rs2;
                    rd_d   = req_rd;
                    kill_d = 1'b0;
                    if (special) begin
                        wb_data_d = special_res;
                        state_d   = S_WB;
                    end else begin
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                fsm_start = 1'b1;
                if (flush) kill_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                fsm_start = 1'b1;
                if (flush) kill_d = 1'b1;
                if (fsm_done) begin
                    wb_data_d = fsm_result;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (flush) kill_d = 1'b1;
                // A killed request still has to wait out the handshake; it just skips WB.
                if (!fsm_done) begin
                    state_d = (kill_q || flush) ? S_IDLE : S_WB;
                    kill_d  = 1'b0;
                end
            end
            S_WB: begin
                wb_valid = !flush;
                if (flush || wb_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= 1'b0;
            n1_q      <= 32'd0;
            n2_q      <= 32'd0;
            rd_q      <= '0;
            wb_data_q <= 32'd0;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            n1_q      <= n1_d;
            n2_q      <= n2_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
            kill_q    <= kill_d;
        end
    end

    assign fsm_sel = op_q;
    assign fsm_n1  = n1_q;
    assign fsm_n2  = n2_q;
    assign wb_rd   = rd_q;
    assign wb_data = wb_data_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Bench for fpu_addsub_issue: a behavioural stand-in for the add/sub FSM plus a writeback scoreboard.
module tb_fpu_addsub_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_op;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        fsm_start, fsm_sel;
    logic [31:0] fsm_n1, fsm_n2;
    logic        fsm_done;
    logic [31:0] fsm_result;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;

    fpu_addsub_issue #(.CANON_NAN(32'h7FC0_0000), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .flush(flush),
        .fsm_start(fsm_start), .fsm_sel(fsm_sel), .fsm_n1(fsm_n1), .fsm_n2(fsm_n2),
        .fsm_done(fsm_done), .fsm_result(fsm_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FSM stand-in: done rises 7 cycles after start is first seen, falls 2 cycles after start drops.
    function automatic logic [31:0] fpu_model(input logic sel, input logic [31:0] a, input logic [31:0] b);
        case ({sel, a, b})
            {1'b0, 32'h3FC00000, 32'h40100000}: return 32'h40700000;
            {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000;
            {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000;
            default:                            return 32'hDEADBEEF;
        endcase
    endfunction

    int stub_cnt = 0;
    int stub_hcnt = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            fsm_done   <= 1'b0;
            fsm_result <= 32'd0;
            stub_cnt   <= 0;
            stub_hcnt  <= 0;
        end else if (!fsm_done) begin
            stub_hcnt <= 0;
            if (fsm_start) begin
                if (stub_cnt == 6) begin
                    fsm_done   <= 1'b1;
                    fsm_result <= fpu_model(fsm_sel, fsm_n1, fsm_n2);
                    stub_cnt   <= 0;
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end
        end else if (!fsm_start) begin
            if (stub_hcnt == 1) begin
                fsm_done  <= 1'b0;
                stub_hcnt <= 0;
            end else begin
                stub_hcnt <= stub_hcnt + 1;
            end
        end
    end

    // Start window tracking and operand stability while the FSM owns them.
    int          start_first = -1, start_last = -1, start_total = 0, stab_err = 0;
    logic        prev_start = 1'b0;
    logic        cap_sel = 1'b0;
    logic [31:0] cap_n1 = '0, cap_n2 = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 1'b0;
        end else begin
            if (fsm_start && !prev_start) begin
                start_first = cyc;
                cap_sel = fsm_sel;
                cap_n1  = fsm_n1;
                cap_n2  = fsm_n2;
            end else if (fsm_start || fsm_done) begin
                if (fsm_sel !== cap_sel || fsm_n1 !== cap_n1 || fsm_n2 !== cap_n2) stab_err++;
            end
            if (fsm_start) begin
                start_last = cyc;
                start_total++;
            end
            prev_start = fsm_start;
        end
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          exp_cyc;
    } exp_t;
    exp_t sb[$];

    int   wb_count = 0;
    int   first_cyc = -1;
    logic prev_wbv = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wbv = 1'b0;
        end else begin
            if (wb_valid && !prev_wbv) first_cyc = cyc;
            prev_wbv = wb_valid;
            if (wb_valid && wb_ready) begin
                wb_count++;
                if (sb.size() == 0) begin
                    check("unexpected writeback", 32'(wb_count), 32'(wb_count - 1));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                    check("wb_data", wb_data, e.data);
                    if (e.exp_cyc >= 0) check("wb latency cycle", 32'(first_cyc), 32'(e.exp_cyc));
                end
            end
        end
    end

    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic push, input logic [31:0] exp,
                         input int lat, output int acc);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
        @(negedge clk);
        check("req_ready at accept", 32'(req_ready), 32'd1);
        acc = cyc;
        if (push) sb.push_back('{rd: rd, data: exp, exp_cyc: (lat < 0) ? -1 : cyc + lat});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1;
                break;
            end
        end
        if (!done) check("idle timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, st, wbc;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
        flush = 1'b0; wb_ready = 1'b1;
        #2;
        check("reset fsm_start", 32'(fsm_start), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset wb_valid", 32'(wb_valid), 32'd0);
        check("reset fsm_n1", fsm_n1, 32'd0);
        check("reset wb_data", wb_data, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);

        // Add through the FSM.
        issue(1'b0, 32'h3FC00000, 32'h40100000, 5'd7, 1'b1, 32'h40700000, 12, acc);
        wait_idle();
        check("add start first", 32'(start_first), 32'(acc + 1));
        check("add start last", 32'(start_last), 32'(acc + 8));

        // Subtract through the FSM.
        issue(1'b1, 32'h40400000, 32'h3F800000, 5'd3, 1'b1, 32'h40000000, 12, acc);
        wait_idle();
        check("sub fsm_sel", 32'(cap_sel), 32'd1);
        check("sub operand stability", 32'(stab_err), 32'd0);

        // Bypass specials.
        st = start_total;
        issue(1'b1, 32'h7F800000, 32'h7F800000, 5'd1, 1'b1, 32'h7FC00000, 1, acc);
        wait_idle();
        issue(1'b0, 32'h7F800000, 32'h3F800000, 5'd2, 1'b1, 32'h7F800000, 1, acc);
        wait_idle();
        issue(1'b1, 32'h3F800000, 32'hFF800000, 5'd4, 1'b1, 32'h7F800000, 1, acc);
        wait_idle();
        issue(1'b0, 32'h7FA00000, 32'h3F800000, 5'd5, 1'b1, 32'h7FC00000, 1, acc);
        wait_idle();
        issue(1'b0, 32'h3F800000, 32'hFF800000, 5'd6, 1'b1, 32'hFF800000, 1, acc);
        wait_idle();
        check("specials never start FSM", 32'(start_total), 32'(st));

        // Backpressure on the writeback port.
        wb_ready = 1'b0;
        wbc = wb_count;
        issue(1'b0, 32'hFF800000, 32'h3F800000, 5'd9, 1'b1, 32'hFF800000, 1, acc);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp wb_valid", 32'(wb_valid), 32'd1);
            check("bp wb_data held", wb_data, 32'hFF800000);
            check("bp wb_rd held", 32'(wb_rd), 32'd9);
            check("bp req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        wb_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        check("bp single writeback", 32'(wb_count), 32'(wbc + 1));

        // Flush pulse in cycle 4 of an FSM-path request.
        wbc = wb_count;
        issue(1'b0, 32'h3F800000, 32'h3F800000, 5'd11, 1'b0, 32'h0, -1, acc);
        while (cyc < acc + 4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        do @(negedge clk); while (cyc < acc + 12);
        check("flush req_ready by cycle 12", 32'(req_ready), 32'd1);
        check("flush fsm_done fell", 32'(fsm_done), 32'd0);
        check("flush no writeback", 32'(wb_count), 32'(wbc));
        check("flush start last", 32'(start_last), 32'(acc + 8));
        issue(1'b0, 32'h3F800000, 32'h3F800000, 5'd12, 1'b1, 32'h40000000, 12, acc);
        wait_idle();

        // Flush while presenting writeback.
        wb_ready = 1'b0;
        wbc = wb_count;
        issue(1'b0, 32'h3F800000, 32'h7F800000, 5'd14, 1'b0, 32'h0, -1, acc);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("wb flush wb_valid", 32'(wb_valid), 32'd0);
        check("wb flush busy", 32'(busy), 32'd0);
        wb_ready = 1'b1;
        @(negedge clk);
        check("wb flush no writeback", 32'(wb_count), 32'(wbc));

        // Reset during WAIT.
        issue(1'b0, 32'h40000000, 32'h40000000, 5'd13, 1'b0, 32'h0, -1, acc);
        while (cyc < acc + 3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst fsm_start", 32'(fsm_start), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst wb_valid", 32'(wb_valid), 32'd0);
        check("midrst fsm_sel", 32'(fsm_sel), 32'd0);
        check("midrst fsm_n1", fsm_n1, 32'd0);
        check("midrst fsm_n2", fsm_n2, 32'd0);
        check("midrst wb_rd", 32'(wb_rd), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst FSM idle", 32'(fsm_done), 32'd0);
        issue(1'b0, 32'h40000000, 32'h40000000, 5'd13, 1'b1, 32'h40800000, 12, acc);
        wait_idle();

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
